fetch_line_buffer: RTL and testbench

Instruction line buffer between the line-granular memory fetch unit and the decoder. Holds one 512-bit cache line, serves the 32-bit instruction at the current PC to the decoder with a valid/ready handshake, advances the PC sequentially, and requests a new line on line crossing or when a redirect misses the buffered line. Owns the fetch PC; the decoder and downstream stages see only `instr`/`instr_pc`.

---
 rtl/fetch_line_buffer_if.sv | 29 ++
 rtl/fetch_line_buffer.sv | 149 ++++++++++++++
 tb/tb_fetch_line_buffer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_line_buffer_if.sv
// Fetch line buffer bus: redirect/entry control, line-granular memory port and decoder handshake.
// master = environment driving the buffer (memory + decoder + redirect source), slave = the buffer itself.
interface fetch_line_buffer_if #(
    parameter int LINE_BITS   = 512,
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]  entry;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [LINE_BITS-1:0]   mem_line;
    logic                   mem_line_valid;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_ready;

    modport master (
        output entry, redirect_valid, redirect_pc, mem_line, mem_line_valid, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        input  entry, redirect_valid, redirect_pc, mem_line, mem_line_valid, instr_ready,
        output mem_req, mem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_line_buffer.sv
// One-line instruction buffer owning the fetch PC; first instr one cycle after line arrival, same cycle with FETCH_BYPASS_EN.
// Backpressure: instr/instr_pc hold while instr_valid && !instr_ready; mem_req/mem_addr hold until mem_line_valid.
module fetch_line_buffer #(
    parameter int LINE_BITS   = 512,
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    fetch_line_buffer_if.slave bus
);
    localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
    localparam int IDX_LSB   = $clog2(INSTR_WIDTH / 8);
    localparam int SLOT_BITS = OFF_BITS - IDX_LSB;
    localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INSTR_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((INSTR_WIDTH / 8) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SERVE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [TAG_BITS-1:0]    tag_q, tag_d;
    logic                   line_ok_q, line_ok_d;

    logic [ADDR_WIDTH-1:0]  redir_pc;
    logic [SLOT_BITS-1:0]   slot;
    logic                   last_slot;
    logic                   redir_hit;
    logic [INSTR_WIDTH-1:0] line_word;
    logic                   serve_vld;
    logic                   byp_vld;
    logic                   instr_vld;
    logic                   accept;

    assign redir_pc  = bus.redirect_pc & ~LOW_MASK;
    assign slot      = pc_q[OFF_BITS-1:IDX_LSB];
    assign last_slot = &slot;
    assign redir_hit = (redir_pc[ADDR_WIDTH-1:OFF_BITS] == tag_q) && line_ok_q;
    assign line_word = line_q[int'(slot) * INSTR_WIDTH +: INSTR_WIDTH];
    assign serve_vld = (state_q == SERVE);

`ifdef FETCH_BYPASS_EN
    logic [INSTR_WIDTH-1:0] mem_word;
    assign mem_word = bus.mem_line[int'(slot) * INSTR_WIDTH +: INSTR_WIDTH];
    // Forward the arriving line straight to the decoder unless a redirect kills it.
    assign byp_vld  = (state_q == FILL) && bus.mem_line_valid && !bus.redirect_valid;
`else
    assign byp_vld  = 1'b0;
`endif

    assign instr_vld = serve_vld || byp_vld;
    assign accept    = instr_vld && bus.instr_ready;

    always_comb begin
        bus.mem_req     = (state_q == FILL);
        bus.mem_addr    = {pc_q[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
        bus.instr_valid = instr_vld;
        bus.instr_pc    = pc_q;
        bus.instr       = '0;
        if (serve_vld) begin
            bus.instr = line_word;
        end
`ifdef FETCH_BYPASS_EN
        else if (byp_vld) begin
            bus.instr = mem_word;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        line_d    = line_q;
        tag_d     = tag_q;
        line_ok_d = line_ok_q;
        case (state_q)
            IDLE: begin
                pc_d    = bus.entry;
                state_d = FILL;
            end
            FILL: begin
                if (bus.redirect_valid) begin
                    // A returning line belongs to the old PC and is dropped; otherwise it is still in flight.
                    pc_d    = redir_pc;
                    state_d = bus.mem_line_valid ? FILL : DRAIN;
                end else if (bus.mem_line_valid) begin
                    line_d    = bus.mem_line;
                    tag_d     = pc_q[ADDR_WIDTH-1:OFF_BITS];
                    line_ok_d = 1'b1;
                    state_d   = SERVE;
                    if (accept) begin
                        pc_d = pc_q + PC_STEP;
                        if (last_slot) begin
                            state_d   = FILL;
                            line_ok_d = 1'b0;
                        end
                    end
                end
            end
            SERVE: begin
                if (bus.redirect_valid) begin
                    pc_d = redir_pc;
                    if (!redir_hit) begin
                        state_d   = FILL;
                        line_ok_d = 1'b0;
                    end
                end else if (accept) begin
                    pc_d = pc_q + PC_STEP;
                    if (last_slot) begin
                        state_d   = FILL;
                        line_ok_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (bus.redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (bus.mem_line_valid) begin
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            line_q    <= '0;
            tag_q     <= '0;
            line_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            line_ok_q <= line_ok_d;
        end
    end
endmodule

// File: tb/tb_fetch_line_buffer.sv
// Scoreboard bench: stimulus pushes the expected PC stream, a negedge monitor pops it on every accepted instruction.
// Memory content is a pure function of address, so every delivered instr is checked against its instr_pc.
module tb_fetch_line_buffer;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_line_buffer_if ifc ();
    fetch_line_buffer dut (.clk(clk), .reset(reset), .bus(ifc));

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] exp_q[$];
    logic [63:0] next_push;
    bit          busy     = 1'b0;
    int          cnt      = 0;
    int          lat_cfg  = 3;
    bit          rand_lat = 1'b0;
    logic [63:0] req_addr = '0;
    int          req_count = 0;
    int          acc_count = 0;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        logic [63:0] w;
        w = a >> 2;
        return (w[31:0] * 32'h9E37_79B1) ^ w[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [511:0] line_of(input logic [63:0] a);
        logic [511:0] l;
        logic [63:0]  base;
        base = {a[63:6], 6'b0};
        for (int i = 0; i < 16; i++) l[32*i +: 32] = word_of(base + 64'(4 * i));
        return l;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_push);
            next_push = next_push + 64'd4;
        end
    endtask

    // One clock: memory model reacts, then this cycle's decoder/redirect inputs are applied.
    task automatic cycle(input bit rdy, input bit redir, input logic [63:0] rpc);
        @(posedge clk);
        #1;
        if (ifc.mem_line_valid) begin
            ifc.mem_line_valid = 1'b0;
            busy = 1'b0;
        end
        if (busy) begin
            cnt--;
            if (cnt <= 0) begin
                ifc.mem_line       = line_of(req_addr);
                ifc.mem_line_valid = 1'b1;
            end
        end else if (ifc.mem_req) begin
            busy     = 1'b1;
            req_addr = ifc.mem_addr;
            req_count++;
            cnt = rand_lat ? int'($urandom_range(1, 5)) : lat_cfg;
        end
        ifc.instr_ready    = rdy;
        ifc.redirect_valid = redir;
        ifc.redirect_pc    = rpc;
        if (redir) begin
            exp_q.delete();
            next_push = {rpc[63:2], 2'b00};
        end
        top_up();
        #1;
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset              = 1'b1;
        ifc.entry          = e;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        ifc.instr_ready    = 1'b0;
        ifc.mem_line_valid = 1'b0;
        ifc.mem_line       = '0;
        busy = 1'b0;
        exp_q.delete();
        next_push = e;
        top_up();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!ifc.instr_valid && k < 40) begin
            cycle(1'b0, 1'b0, '0);
            k++;
        end
        if (!ifc.instr_valid) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: instr_valid not seen within 40 cycles", name);
        end
    endtask

    initial begin : monitor
        logic [63:0] hold_pc;
        logic [31:0] hold_instr;
        logic [63:0] e;
        bit          hold;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (busy && ifc.mem_req) chk("mem_addr_stable", ifc.mem_addr, req_addr);
                if (hold) begin
                    chk("hold_valid", 64'(ifc.instr_valid), 64'd1);
                    chk("hold_pc", ifc.instr_pc, hold_pc);
                    chk("hold_instr", 64'(ifc.instr), 64'(hold_instr));
                end
                if (ifc.instr_valid && ifc.instr_ready && !ifc.redirect_valid) begin
                    acc_count++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL sb_empty: accepted pc 0x%h with no expected entry", ifc.instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", ifc.instr_pc, e);
                        chk("sb_instr", 64'(ifc.instr), 64'(word_of(e)));
                    end
                end
                hold       = ifc.instr_valid && !ifc.instr_ready && !ifc.redirect_valid;
                hold_pc    = ifc.instr_pc;
                hold_instr = ifc.instr;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [511:0] ln;
        logic [31:0]  w;
        logic [63:0]  p0, t;
        logic [31:0]  i0;
        int           k, a0, base;
        bit           r, rd;

        do_reset(64'h8000_0010);
        // IDLE cycle right after release: everything still at reset values
        chk("rst_mem_req", 64'(ifc.mem_req), 64'd0);
        chk("rst_mem_addr", ifc.mem_addr, 64'd0);
        chk("rst_instr_valid", 64'(ifc.instr_valid), 64'd0);
        chk("rst_instr", 64'(ifc.instr), 64'd0);
        chk("rst_instr_pc", ifc.instr_pc, 64'd0);

        cycle(1'b0, 1'b0, '0);
        chk("fill_mem_req", 64'(ifc.mem_req), 64'd1);
        chk("fill_mem_addr", ifc.mem_addr, 64'h8000_0000);
        k = 0;
        while (!ifc.mem_line_valid && k < 20) begin
            cycle(1'b0, 1'b0, '0);
            k++;
        end
        chk("line_latency", 64'(k), 64'd3);
        chk("valid_on_arrival", 64'(ifc.instr_valid), 64'(BYP));
        cycle(1'b0, 1'b0, '0);
        ln = line_of(64'h8000_0000);
        w  = ln[159:128];
        chk("first_valid", 64'(ifc.instr_valid), 64'd1);
        chk("first_pc", ifc.instr_pc, 64'h8000_0010);
        chk("first_instr", 64'(ifc.instr), 64'(w));

        // redirect hit within the buffered line
        cycle(1'b0, 1'b1, 64'h8000_0004);
        cycle(1'b0, 1'b0, '0);
        chk("hit_no_req", 64'(ifc.mem_req), 64'd0);
        chk("hit_valid", 64'(ifc.instr_valid), 64'd1);
        chk("hit_pc", ifc.instr_pc, 64'h8000_0004);

        // line crossing from the last two slots
        cycle(1'b0, 1'b1, 64'h8000_0038);
        cycle(1'b1, 1'b0, '0);
        chk("cross_pc38", ifc.instr_pc, 64'h8000_0038);
        cycle(1'b1, 1'b0, '0);
        chk("cross_pc3c", ifc.instr_pc, 64'h8000_003C);
        cycle(1'b0, 1'b0, '0);
        chk("cross_req", 64'(ifc.mem_req), 64'd1);
        chk("cross_addr", ifc.mem_addr, 64'h8000_0040);
        chk("cross_invalid", 64'(ifc.instr_valid), 64'd0);
        base = req_count;
        wait_valid("wait_line40");

        // 16 back-to-back accepts consume the line and issue exactly one new request
        a0 = acc_count;
        k  = 0;
        while ((acc_count - a0) < 16 && k < 60) begin
            cycle(1'b1, 1'b0, '0);
            @(negedge clk);
            #1;
            k++;
        end
        chk("accepts16", 64'(acc_count - a0), 64'd16);
        cycle(1'b0, 1'b0, '0);
        chk("one_req_per_line", 64'(req_count - base), 64'd1);
        chk("next_line_addr", ifc.mem_addr, 64'h8000_0080);
        wait_valid("wait_line80");

        // miss redirect, then redirect while that fill is in flight
        lat_cfg = 2;
        cycle(1'b0, 1'b1, 64'h9000_0000);
        cycle(1'b0, 1'b0, '0);
        chk("miss_req", 64'(ifc.mem_req), 64'd1);
        chk("miss_addr", ifc.mem_addr, 64'h9000_0000);
        cycle(1'b0, 1'b1, 64'hA000_0000);
        cycle(1'b0, 1'b0, '0);
        chk("drain_no_req", 64'(ifc.mem_req), 64'd0);
        chk("drain_invalid", 64'(ifc.instr_valid), 64'd0);
        cycle(1'b0, 1'b0, '0);
        chk("refill_req", 64'(ifc.mem_req), 64'd1);
        chk("refill_addr", ifc.mem_addr, 64'hA000_0000);
        chk("refill_invalid", 64'(ifc.instr_valid), 64'd0);
        wait_valid("wait_lineA0");
        chk("redir_pc", ifc.instr_pc, 64'hA000_0000);
        chk("redir_instr", 64'(ifc.instr), 64'(word_of(64'hA000_0000)));

        // backpressure: outputs frozen for five cycles
        p0 = ifc.instr_pc;
        i0 = ifc.instr;
        repeat (5) cycle(1'b0, 1'b0, '0);
        chk("bp_pc", ifc.instr_pc, p0);
        chk("bp_instr", 64'(ifc.instr), 64'(i0));

        // asynchronous reset in the middle of a fill
        lat_cfg = 4;
        cycle(1'b0, 1'b1, 64'hB000_0000);
        cycle(1'b0, 1'b0, '0);
        chk("pre_rst_req", 64'(ifc.mem_req), 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_mem_req", 64'(ifc.mem_req), 64'd0);
        chk("arst_mem_addr", ifc.mem_addr, 64'd0);
        chk("arst_instr_valid", 64'(ifc.instr_valid), 64'd0);
        chk("arst_instr", 64'(ifc.instr), 64'd0);
        chk("arst_instr_pc", ifc.instr_pc, 64'd0);

        // randomized traffic: random latency, ready and redirects (hit, wrap-around, far, next line)
        do_reset(64'h0000_1000);
        rand_lat = 1'b1;
        a0 = acc_count;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 3) != 0);
            rd = (i >= 2) && ($urandom_range(0, 11) == 0);
            t  = '0;
            if (rd) begin
                case ($urandom_range(0, 3))
                    0: begin
                        t = exp_q[0];
                        t[5:0] = 6'($urandom_range(0, 15) << 2);
                    end
                    1: begin
                        t = 64'hFFFF_FFFF_FFFF_FFC0;
                        t[5:0] = 6'($urandom_range(8, 15) << 2);
                    end
                    2: t = {$urandom, $urandom};
                    default: begin
                        t = exp_q[0] + 64'd64;
                        t[5:0] = 6'($urandom_range(0, 15) << 2);
                    end
                endcase
            end
            cycle(r, rd, t);
        end
        cycle(1'b0, 1'b0, '0);
        chk("random_progress", 64'((acc_count - a0) > 500), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
